// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared encodings and constants for the keypad scanner
package key_scan_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   localparam int         NUM_ROWS  = 4;
   localparam int         NUM_COLS  = 4;
   localparam logic [3:0] COL_IDLE  = 4'b1111;
   localparam logic [3:0] ROW_RESET = 4'b1110;

   // Lowest-numbered active-low column wins when several are pressed together.
   function automatic logic [1:0] first_low_col(input logic [NUM_COLS-1:0] p);
      first_low_col = 2'd0;
      for (int i = NUM_COLS - 1; i >= 0; i--) begin
         if (!p[i]) first_low_col = i[1:0];
      end
   endfunction

endpackage

// File: rtl/key_col_sync.sv
// rtl/key_col_sync.sv - two-flop synchronizer for the asynchronous column lines
module key_col_sync
   import key_scan_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_COLS-1:0] d,
   output logic [NUM_COLS-1:0] q
);

   logic [NUM_COLS-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= COL_IDLE;
         q    <= COL_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - 4x4 keypad scanner with debounce and valid/ack key output
// Optional auto-repeat of a held key: define KEY_SCAN_REPEAT_EN.
module key_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 500000,
   parameter int REPEAT_CNT   = 25000000
) (
   input  logic                clk,
   input  logic                rst,
   output logic [NUM_ROWS-1:0] row,
   input  logic [NUM_COLS-1:0] col,
   output logic [3:0]          key_code,
   output logic                key_valid,
   input  logic                key_ack,
   output logic                key_down,
   output logic                overrun
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(DEBOUNCE_CNT);

   state_t              state, state_nxt;
   logic [DW-1:0]       dwell, dwell_nxt;
   logic [BW-1:0]       db, db_nxt;
   logic [1:0]          row_idx, row_idx_nxt;
   logic [NUM_COLS-1:0] pat, pat_nxt;
   logic [NUM_COLS-1:0] cs;
   logic                issue;
   logic                rep_fire;

   key_col_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (col),
      .q   (cs)
   );

   assign row      = ~(~ROW_RESET << row_idx);
   assign key_down = (state == HELD) || (state == REL_DB);

`ifdef KEY_SCAN_REPEAT_EN
   localparam int RW = $clog2(REPEAT_CNT);
   logic [RW-1:0] rep_cnt;

   assign rep_fire = (state == HELD) && (rep_cnt == RW'(REPEAT_CNT - 1));

   // Held at zero outside HELD, so every entry to HELD starts a fresh interval.
   always_ff @(posedge clk) begin
      if (rst || state != HELD || rep_fire) rep_cnt <= '0;
      else                                  rep_cnt <= rep_cnt + 1'b1;
   end
`else
   assign rep_fire = (REPEAT_CNT < 0);
`endif

   always_comb begin
      state_nxt   = state;
      dwell_nxt   = dwell;
      db_nxt      = db;
      row_idx_nxt = row_idx;
      pat_nxt     = pat;
      issue       = 1'b0;
      case (state)
         SCAN: begin
            if (dwell == DW'(SCAN_DIV - 1)) begin
               dwell_nxt = '0;
               if (cs == COL_IDLE) begin
                  row_idx_nxt = row_idx + 2'd1;
               end else begin
                  pat_nxt   = cs;
                  db_nxt    = '0;
                  state_nxt = PRESS_DB;
               end
            end else begin
               dwell_nxt = dwell + 1'b1;
            end
         end
         PRESS_DB: begin
            if (cs != pat) begin
               db_nxt    = '0;
               state_nxt = SCAN;
            end else if (db == BW'(DEBOUNCE_CNT - 1)) begin
               db_nxt    = '0;
               issue     = 1'b1;
               state_nxt = HELD;
            end else begin
               db_nxt = db + 1'b1;
            end
         end
         HELD: begin
            issue = rep_fire;
            if (cs == COL_IDLE) begin
               db_nxt    = '0;
               state_nxt = REL_DB;
            end
         end
         REL_DB: begin
            if (cs != COL_IDLE) begin
               db_nxt    = '0;
               state_nxt = HELD;
            end else if (db == BW'(DEBOUNCE_CNT - 1)) begin
               db_nxt      = '0;
               row_idx_nxt = row_idx + 2'd1;
               state_nxt   = SCAN;
            end else begin
               db_nxt = db + 1'b1;
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SCAN;
         dwell   <= '0;
         db      <= '0;
         row_idx <= 2'd0;
         pat     <= COL_IDLE;
      end else begin
         state   <= state_nxt;
         dwell   <= dwell_nxt;
         db      <= db_nxt;
         row_idx <= row_idx_nxt;
         pat     <= pat_nxt;
      end
   end

   // An unacknowledged key is never overwritten; the new one is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (issue) begin
         if (!key_valid || key_ack) begin
            key_code  <= {row_idx, first_low_col(pat)};
            key_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (key_ack) begin
         key_valid <= 1'b0;
      end
   end

endmodule

// File: doc/key_scan.md
Name: key_scan

Overview:
- Matrix keypad reader: drives the rows of a 4x4 key matrix one at a time (active-low one-hot) and reads back the column lines.
- Debounces press and release, encodes the key as row*4+col, and presents it on a valid/ack handshake.
- Sits beside the display digit scanner on the front-panel I/O and feeds key codes to the SoC register interface.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven before its columns are sampled (min 4).
- DEBOUNCE_CNT, 500000: cycles the column pattern must stay stable to accept a press or release (min 2).
- REPEAT_CNT, 25000000: cycles a held key waits before re-issue; used only with KEY_SCAN_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- row  out  4  row drive, active-low one-hot; row[i]=0 selects row i.
- col  in  4  column sense, active-low, pulled up externally, asynchronous.
- key_code  out  4  accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  key_code is valid; held until acknowledged.
- key_ack  in  1  consumer accepts key_code.
- key_down  out  1  high while a debounced key is held.
- overrun  out  1  sticky; a key was dropped because key_valid was still high.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset is synchronous and active-high, named rst; all flops reset on a clk edge with rst=1.
- Reset values:
  - row=4'b1110; state SCAN; row index 0; all counters 0.
  - Synchronizer flops=4'b1111.
  - key_code=0, key_valid=0, key_down=0, overrun=0.
- col passes a 2-flop synchronizer; all logic uses the synchronized value cs. Latency from col to cs is 2 cycles.
- SCAN:
  - row is driven continuously and the dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, cs is sampled.
  - If cs==4'b1111: advance the row index 0,1,2,3,0 (wraps), update row next cycle, clear the counter.
  - Otherwise: capture row index and pattern p=cs, then go to PRESS_DB with the row held.
- PRESS_DB:
  - Each cycle, if cs==p the counter increments; otherwise return to SCAN on the same row with the counter cleared.
  - When the counter reaches DEBOUNCE_CNT-1: go to HELD and issue the key.
- Key issue:
  - col_idx is the lowest index i with p[i]=0; several columns low is not an error.
  - If key_valid is 0, or key_ack=1 in the same cycle: load key_code and set key_valid=1 next cycle.
  - Otherwise keep the old key and set overrun=1.
- HELD:
  - key_down=1 and row is held.
  - When cs==4'b1111: go to REL_DB with the counter cleared.
- REL_DB:
  - Requires cs==4'b1111 for DEBOUNCE_CNT consecutive cycles, then returns to SCAN on the next row with key_down=0.
  - Any low column returns to HELD.
- Handshake:
  - key_valid falls the cycle after key_ack is sampled high.
  - key_ack with key_valid=0 is ignored.
  - key_code is stable while key_valid=1.
- overrun is cleared only by rst.
- Counter widths are $clog2 of the parameter; counters never wrap beyond their terminal count.
- rst mid-debounce or while HELD returns to the reset state immediately; no key is issued.

Optional Feature:
- Macro: KEY_SCAN_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts to REPEAT_CNT-1, then re-issues the same key_code under the same issue/overrun rules and restarts.
  - The repeat counter clears on entry to HELD.
- Undefined: each press issues exactly once; the REPEAT_CNT parameter has no effect and no repeat logic is synthesized.

Decomposition:
- Shared package key_scan_pkg holds:
  - state encodings SCAN, PRESS_DB, HELD, REL_DB (2-bit);
  - NUM_ROWS=4, NUM_COLS=4;
  - COL_IDLE=4'b1111;
  - ROW_RESET=4'b1110.
- One sub-module, key_col_sync: 4-bit 2-flop synchronizer, reset value 4'b1111.
- FSM, counters and handshake stay in key_scan.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=32.
1. Reset, col=4'b1111 for 40 cycles -> row cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid=0.
2. Pull col[2] low only while row=1011 (row 2), hold 100 cycles -> key_code=4'hA, key_valid=1, key_down=1; key_ack pulse -> key_valid=0 next cycle.
3. Press row 1 col 0 with bounce (toggle every 3 cycles for 20 cycles, then stable low) -> exactly one key_code=4'h4 issued.
4. Press 4'h4, do not ack, release, press 4'hF -> key_code stays 4'h4, overrun=1; then ack -> key_valid=0, overrun stays 1.
5. Key held, rst=1 for 1 cycle -> next cycle row=1110, key_valid=0, key_down=0, overrun=0.
6. KEY_SCAN_REPEAT_EN defined, hold 4'h0 with ack each issue -> key_code=4'h0 reissued every 32 cycles; undefined -> single issue.
